if_fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined LC-3b core, directly upstream of the IF/ID pipeline latch. It owns the fetch PC, runs a single-outstanding read handshake to instruction memory, and buffers returned words with their PC+2. Each unstalled cycle it presents one instruction, or a NOP bubble, to the IF/ID latch. It also accepts branch/jump redirects from later stages and squashes wrong-path fetches.

---
 rtl/if_fetch_stage_pkg.sv | 32 +++
 rtl/if_fetch_stage_fifo.sv | 72 +++++++
 rtl/if_fetch_stage.sv | 114 +++++++++++
 tb/tb_if_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared types for the LC-3b instruction-fetch stage.
// Defining IF_SKID_EN gives a two-entry fetch buffer (1 instr/cycle); otherwise the buffer holds one entry.
package if_fetch_stage_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        lc3b_word pc;
        lc3b_word instr;
    } fetch_entry_t;

    // BR with nzp=000 never branches, so it is a safe bubble.
    localparam lc3b_word LC3B_NOP = 16'h0000;

`ifdef IF_SKID_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

    localparam int FETCH_CNT_W = $clog2(FETCH_DEPTH + 1);

    function automatic lc3b_word pc_plus2(input lc3b_word pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/if_fetch_stage_fifo.sv
// Small register FIFO of {pc+2, instr} fetch entries with flush, push/pop and occupancy count.
module if_fetch_stage_fifo
    import if_fetch_stage_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  fetch_entry_t     i_data,
    input  logic             i_pop,
    output fetch_entry_t     o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [DEPTH-1:0] w_wr_en;
    logic             w_push;
    logic             w_pop;

    // A flush wins over any push or pop in the same cycle.
    assign w_push = i_push & ~i_flush;
    assign w_pop  = i_pop & ~i_flush & (r_count != '0);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign w_wr_en[gi] = w_push & (r_wr_ptr == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_en[i]) r_mem[i] <= i_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/if_fetch_stage.sv
// LC-3b instruction-fetch stage: fetch PC, single-outstanding imem handshake, redirect/drain handling.
// IF_SKID_EN (see package) selects the two-entry fetch buffer.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000,
    parameter lc3b_word NOP_WORD = LC3B_NOP
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_target,
    output logic        o_imem_read,
    output logic [15:0] o_imem_address,
    input  logic [15:0] i_imem_rdata,
    input  logic        i_imem_resp,
    output logic        o_ifid_load,
    output logic [15:0] o_ifid_pc,
    output logic [15:0] o_ifid_instruction
);

    localparam logic [FETCH_CNT_W-1:0] DEPTH_CNT = FETCH_CNT_W'(FETCH_DEPTH);

    fetch_state_t           r_state;
    lc3b_word               r_fetch_pc;
    lc3b_word               r_drain_addr;
    logic                   r_pending;
    logic                   r_run;

    fetch_state_t           w_state_next;
    lc3b_word               w_fetch_pc_next;
    lc3b_word               w_imem_address;
    lc3b_word               w_target;
    logic                   w_imem_read;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_present;
    logic [FETCH_CNT_W-1:0] w_count;
    fetch_entry_t           w_head;
    fetch_entry_t           w_push_entry;

    assign w_target = i_redirect_target & 16'hFFFE;

    // Read stays up while a request is pending so address/read are stable until the response.
    always_comb begin
        w_state_next   = r_state;
        w_imem_read    = 1'b0;
        w_imem_address = r_fetch_pc;
        case (r_state)
            ST_FETCH: begin
                w_imem_read = r_run & ((w_count < DEPTH_CNT) | r_pending);
                if (i_redirect && w_imem_read && !i_imem_resp) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_imem_read    = 1'b1;
                w_imem_address = r_drain_addr;
                if (i_imem_resp) w_state_next = ST_FETCH;
            end
            default: w_state_next = ST_FETCH;
        endcase
    end

    assign w_accept = w_imem_read & i_imem_resp;
    assign w_push   = (r_state == ST_FETCH) & w_accept & ~i_redirect;
    assign w_pop    = o_ifid_load & (w_count != '0) & ~i_redirect;

    assign w_push_entry.pc    = pc_plus2(r_fetch_pc);
    assign w_push_entry.instr = i_imem_rdata;

    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        if (i_redirect)  w_fetch_pc_next = w_target;
        else if (w_push) w_fetch_pc_next = pc_plus2(r_fetch_pc);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_FETCH;
            r_fetch_pc   <= RESET_PC;
            r_drain_addr <= '0;
            r_pending    <= 1'b0;
            r_run        <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_pending  <= w_imem_read & ~i_imem_resp;
            r_run      <= 1'b1;
            if (r_state == ST_FETCH && w_state_next == ST_DRAIN) r_drain_addr <= r_fetch_pc;
        end
    end

    if_fetch_stage_fifo #(
        .DEPTH (FETCH_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_redirect),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign w_present          = (w_count != '0) & ~i_redirect;
    assign o_imem_read        = w_imem_read;
    assign o_imem_address     = w_imem_address;
    assign o_ifid_load        = ~i_stall;
    assign o_ifid_pc          = w_present ? w_head.pc : 16'h0000;
    assign o_ifid_instruction = w_present ? w_head.instr : NOP_WORD;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; expectations adapt to the buffer depth chosen by IF_SKID_EN.
module tb_if_fetch_stage;

`ifdef IF_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_stall;
    logic        i_redirect;
    logic [15:0] i_redirect_target;
    logic        o_imem_read;
    logic [15:0] o_imem_address;
    logic [15:0] i_imem_rdata;
    logic        i_imem_resp;
    logic        o_ifid_load;
    logic [15:0] o_ifid_pc;
    logic [15:0] o_ifid_instruction;

    int checks = 0;
    int errors = 0;

    logic [15:0] x_addr;
    logic [15:0] y_addr;

    if_fetch_stage dut (
        .i_clk              (clk),
        .i_rst_n            (i_rst_n),
        .i_stall            (i_stall),
        .i_redirect         (i_redirect),
        .i_redirect_target  (i_redirect_target),
        .o_imem_read        (o_imem_read),
        .o_imem_address     (o_imem_address),
        .i_imem_rdata       (i_imem_rdata),
        .i_imem_resp        (i_imem_resp),
        .o_ifid_load        (o_ifid_load),
        .o_ifid_pc          (o_ifid_pc),
        .o_ifid_instruction (o_ifid_instruction)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1234;
        if (a == 16'h0002) return 16'h5678;
        return a ^ 16'hA5A5;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, answer the read if resp_en.
    task automatic cyc(input bit resp_en, input bit stall, input bit redir, input logic [15:0] tgt);
        @(negedge clk);
        i_stall           = stall;
        i_redirect        = redir;
        i_redirect_target = tgt;
        i_imem_resp       = 1'b0;
        i_imem_rdata      = 16'hDEAD;
        #1;
        if (resp_en && o_imem_read) begin
            i_imem_rdata = mem_word(o_imem_address);
            i_imem_resp  = 1'b1;
        end
        #1;
        $display("t=%0t stall=%0b redir=%0b resp=%0b | read=%0b addr=%h | ifid pc=%h instr=%h",
                 $time, i_stall, i_redirect, i_imem_resp, o_imem_read, o_imem_address,
                 o_ifid_pc, o_ifid_instruction);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_target = '0;
        i_imem_resp = 1'b0; i_imem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_read",  16'(o_imem_read), 16'h0000);
        chk("rst_instr", o_ifid_instruction, 16'h0000);
        chk("rst_pc",    o_ifid_pc, 16'h0000);
        chk("rst_load",  16'(o_ifid_load), 16'h0001);
        i_stall = 1'b1; #1;
        chk("rst_load_stall", 16'(o_ifid_load), 16'h0000);
        i_stall = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1; #1;
        chk("release_read", 16'(o_imem_read), 16'h0000);

        // Zero-wait memory from reset.
        cyc(1, 0, 0, 0);
        chk("c1_read", 16'(o_imem_read), 16'h0001);
        chk("c1_addr", o_imem_address, 16'h0000);
        chk("c1_instr", o_ifid_instruction, 16'h0000);
        cyc(1, 0, 0, 0);
        chk("c2_instr", o_ifid_instruction, 16'h1234);
        chk("c2_pc", o_ifid_pc, 16'h0002);
        chk("c2_read", 16'(o_imem_read), SKID ? 16'h0001 : 16'h0000);
        chk("c2_addr", o_imem_address, 16'h0002);
        cyc(1, 0, 0, 0);
        chk("c3_instr", o_ifid_instruction, SKID ? 16'h5678 : 16'h0000);
        chk("c3_pc", o_ifid_pc, SKID ? 16'h0004 : 16'h0000);
        cyc(1, 0, 0, 0);
        chk("c4_instr", o_ifid_instruction, SKID ? 16'hA5A1 : 16'h5678);
        chk("c4_pc", o_ifid_pc, SKID ? 16'h0006 : 16'h0004);

        // Stall fills the buffer, then 3 stalled cycles with nothing moving.
        cyc(1, 1, 0, 0);
        chk("c5_load", 16'(o_ifid_load), 16'h0000);
        chk("c5_instr", o_ifid_instruction, SKID ? 16'hA5A3 : 16'h0000);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 0, 0);
            chk("stall_read", 16'(o_imem_read), 16'h0000);
            chk("stall_instr", o_ifid_instruction, SKID ? 16'hA5A3 : 16'hA5A1);
            chk("stall_pc", o_ifid_pc, SKID ? 16'h0008 : 16'h0006);
        end
        cyc(0, 0, 0, 0);
        chk("resume_instr", o_ifid_instruction, SKID ? 16'hA5A3 : 16'hA5A1);
        chk("resume_read", 16'(o_imem_read), 16'h0000);
        cyc(0, 0, 0, 0);
        x_addr = SKID ? 16'h000A : 16'h0006;
        chk("c10_read", 16'(o_imem_read), 16'h0001);
        chk("c10_addr", o_imem_address, x_addr);
        chk("c10_instr", o_ifid_instruction, SKID ? 16'hA5AD : 16'h0000);

        // Slow memory: request held stable across waiting cycles, stalled or not.
        cyc(0, 1, 0, 0);
        chk("lat1_read", 16'(o_imem_read), 16'h0001);
        chk("lat1_addr", o_imem_address, x_addr);
        cyc(0, 0, 0, 0);
        chk("lat2_addr", o_imem_address, x_addr);
        cyc(1, 0, 0, 0);
        chk("lat3_addr", o_imem_address, x_addr);
        chk("lat3_resp", 16'(i_imem_resp), 16'h0001);
        cyc(0, 0, 0, 0);
        chk("lat_instr", o_ifid_instruction, x_addr ^ 16'hA5A5);
        chk("lat_pc", o_ifid_pc, x_addr + 16'h0002);

        // Redirect while a request is outstanding: drain the old response.
        y_addr = x_addr + 16'h0002;
        cyc(0, 0, 1, 16'h3001);
        chk("redir_read", 16'(o_imem_read), 16'h0001);
        chk("redir_addr", o_imem_address, y_addr);
        chk("redir_instr", o_ifid_instruction, 16'h0000);
        cyc(0, 0, 0, 0);
        chk("drain_addr", o_imem_address, y_addr);
        chk("drain_instr", o_ifid_instruction, 16'h0000);
        cyc(1, 0, 0, 0);
        chk("drain_resp_addr", o_imem_address, y_addr);
        cyc(0, 0, 0, 0);
        chk("post_drain_addr", o_imem_address, 16'h3000);
        chk("post_drain_instr", o_ifid_instruction, 16'h0000);
        cyc(1, 0, 0, 0);
        chk("tgt_addr", o_imem_address, 16'h3000);
        cyc(0, 0, 0, 0);
        chk("tgt_instr", o_ifid_instruction, 16'h95A5);
        chk("tgt_pc", o_ifid_pc, 16'h3002);
        chk("tgt_read", 16'(o_imem_read), SKID ? 16'h0001 : 16'h0000);

        // Redirect coinciding with a response: data dropped, no drain.
        cyc(1, 0, 1, 16'hFFFF);
        chk("redir_resp_read", 16'(o_imem_read), 16'h0001);
        chk("redir_resp_instr", o_ifid_instruction, 16'h0000);
        cyc(1, 0, 0, 0);
        chk("wrap_addr", o_imem_address, 16'hFFFE);
        chk("wrap_empty", o_ifid_instruction, 16'h0000);
        cyc(0, 1, 0, 0);
        chk("wrap_pc", o_ifid_pc, 16'h0000);
        chk("wrap_instr", o_ifid_instruction, 16'h5A5B);
        chk("wrap_next_addr", o_imem_address, 16'h0000);

        // Redirect with no request in flight (single-entry) vs. pending (two-entry).
        cyc(0, 1, 1, 16'h0100);
        chk("redir2_instr", o_ifid_instruction, 16'h0000);
        cyc(1, 0, 0, 0);
        chk("redir2_read", 16'(o_imem_read), 16'h0001);
        chk("redir2_addr", o_imem_address, SKID ? 16'h0000 : 16'h0100);
        cyc(0, 0, 0, 0);
        chk("redir2_out", o_ifid_instruction, SKID ? 16'h0000 : 16'hA4A5);
        chk("redir2_pc", o_ifid_pc, SKID ? 16'h0000 : 16'h0102);
        chk("redir2_next", o_imem_address, SKID ? 16'h0100 : 16'h0102);
        cyc(0, 0, 0, 0);
        chk("pre_rst_read", 16'(o_imem_read), 16'h0001);

        // Asynchronous reset mid-request drops the read immediately.
        i_rst_n = 1'b0; #1;
        chk("async_rst_read", 16'(o_imem_read), 16'h0000);
        chk("async_rst_instr", o_ifid_instruction, 16'h0000);
        chk("async_rst_pc", o_ifid_pc, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
